// File: rtl/uart_loader_pkg.sv
// Shared definitions for the UART instruction-memory loader.
// FSM encodings, word geometry and byte-lane selection.
package uart_loader_pkg;

    localparam int WORD_BYTES = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_WRITE   = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    // Byte lane of the idx-th received byte within the word.
    function automatic logic [1:0] lane_of(
        input logic [1:0] idx,
        input logic       big
    );
        return big ? (2'(WORD_BYTES - 1) - idx) : idx;
    endfunction

endpackage

// File: rtl/uart_loader.sv
// uart_loader: packs a UART byte stream into 32-bit words and writes them
// to instruction memory while holding the CPU in reset.
module uart_loader
    import uart_loader_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic              i_clk_uart,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [7:0]        i_rx_data,
    input  logic              i_rx_valid,
    input  logic              i_rx_clear,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [31:0]       o_mem_wdata,
    output logic              o_mem_we,
    input  logic              i_mem_ready,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_cpu_rst_n,
    output logic [ADDR_W:0]   o_word_count,
    output logic              o_overflow
);

    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [1:0]        r_idx;
    logic [ADDR_W:0]   r_count;
    logic              r_ovf;
    logic              r_full;
    logic              r_flush;
    logic              r_skid_valid;
    logic [7:0]        r_skid_data;

    logic              w_accept;
    logic              w_have;
    logic [7:0]        w_byte;
    logic              w_store;
    logic              w_drop;
    logic [1:0]        w_idx_nxt;
    logic [1:0]        w_lane;
    logic              w_word_done;
    logic              w_clear;
    logic              w_flush_wr;
    logic              w_skid_after;

    // The skid byte always goes ahead of a byte arriving in the same cycle.
    assign w_accept     = (r_state == ST_WRITE) && i_mem_ready;
    assign w_have       = r_skid_valid | i_rx_valid;
    assign w_byte       = r_skid_valid ? r_skid_data : i_rx_data;
    assign w_store      = w_have & ~r_full;
    assign w_drop       = w_have & r_full;
    assign w_idx_nxt    = r_idx + {1'b0, w_store};
    assign w_lane       = lane_of(r_idx, BIG_ENDIAN);
    assign w_word_done  = w_store && (r_idx == 2'd3);
    assign w_clear      = i_rx_clear | r_flush;
    assign w_flush_wr   = r_flush | i_rx_clear;
    assign w_skid_after = r_skid_valid | i_rx_valid;

    assign o_mem_addr   = r_addr;
    assign o_mem_wdata  = r_wdata;
    assign o_word_count = r_count;
    assign o_overflow   = r_ovf;

    // State register.
    always_ff @(posedge i_clk_uart) begin
        if (!i_rst_n) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Next-state decode and state-derived outputs.
    always_comb begin
        w_state_nxt = r_state;
        o_mem_we    = 1'b0;
        o_busy      = 1'b0;
        o_done      = 1'b0;
        o_cpu_rst_n = 1'b1;
        unique case (r_state)
            ST_IDLE: begin
                if (i_start) w_state_nxt = ST_COLLECT;
            end
            ST_COLLECT: begin
                o_busy = 1'b1;
                if (w_word_done)
                    w_state_nxt = ST_WRITE;
                else if (w_clear && (w_idx_nxt != 2'd0))
                    w_state_nxt = ST_WRITE;
                else if (w_clear && (r_count != '0))
                    w_state_nxt = ST_DONE;
            end
            ST_WRITE: begin
                o_busy   = 1'b1;
                o_mem_we = 1'b1;
                // A pending byte must still be flushed before finishing.
                if (w_accept)
                    w_state_nxt = (w_flush_wr && !w_skid_after) ?
                                  ST_DONE : ST_COLLECT;
            end
            ST_DONE: begin
                o_done      = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        if (o_busy) o_cpu_rst_n = 1'b0;
    end

    // Word assembler, skid buffer, address and status counters.
    always_ff @(posedge i_clk_uart) begin
        if (!i_rst_n) begin
            r_addr       <= '0;
            r_wdata      <= '0;
            r_idx        <= '0;
            r_count      <= '0;
            r_ovf        <= 1'b0;
            r_full       <= 1'b0;
            r_flush      <= 1'b0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_addr       <= '0;
                        r_wdata      <= '0;
                        r_idx        <= '0;
                        r_count      <= '0;
                        r_ovf        <= 1'b0;
                        r_full       <= 1'b0;
                        r_flush      <= 1'b0;
                        r_skid_valid <= 1'b0;
                    end
                end
                ST_COLLECT: begin
                    if (w_store) begin
                        r_wdata[{w_lane, 3'b000} +: 8] <= w_byte;
                        r_idx <= w_idx_nxt;
                    end
                    if (w_drop) r_ovf <= 1'b1;
                    if (r_skid_valid) begin
                        if (i_rx_valid) r_skid_data  <= i_rx_data;
                        else            r_skid_valid <= 1'b0;
                    end
                    r_flush <= (w_state_nxt == ST_WRITE) ? w_clear : 1'b0;
                end
                ST_WRITE: begin
                    if (i_rx_valid) begin
                        if (r_skid_valid) begin
                            r_ovf <= 1'b1;
                        end else begin
                            r_skid_valid <= 1'b1;
                            r_skid_data  <= i_rx_data;
                        end
                    end
                    if (i_rx_clear) r_flush <= 1'b1;
                    if (w_accept) begin
                        r_count <= r_count + CNT_ONE;
                        r_wdata <= '0;
                        if (r_addr == ADDR_MAX) r_full <= 1'b1;
                        else                    r_addr <= r_addr + ADDR_ONE;
                        if (w_state_nxt == ST_DONE) r_flush <= 1'b0;
                    end
                end
                ST_DONE: begin
                    r_flush <= 1'b0;
                end
                default: begin
                    r_flush <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_loader.sv
// Directed bench for uart_loader: three instances (big-endian, little-endian,
// 2-bit address) share one stimulus bus; written words are captured per DUT.
module tb_uart_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_clear;
    logic        mem_ready;

    logic [7:0]  a0, a1;
    logic [1:0]  a2;
    logic [31:0] wd0, wd1, wd2;
    logic        we0, we1, we2;
    logic        busy0, busy1, busy2;
    logic        done0, done1, done2;
    logic        cpu0, cpu1, cpu2;
    logic [8:0]  cnt0, cnt1;
    logic [2:0]  cnt2;
    logic        ovf0, ovf1, ovf2;

    logic [39:0] q0[$];
    logic [39:0] q1[$];
    logic [39:0] q2[$];
    int          dn0;
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    uart_loader #(.ADDR_W(8), .BIG_ENDIAN(1'b1)) u_be (
        .i_clk_uart(clk), .i_rst_n(rst_n), .i_start(start),
        .i_rx_data(rx_data), .i_rx_valid(rx_valid), .i_rx_clear(rx_clear),
        .o_mem_addr(a0), .o_mem_wdata(wd0), .o_mem_we(we0),
        .i_mem_ready(mem_ready), .o_busy(busy0), .o_done(done0),
        .o_cpu_rst_n(cpu0), .o_word_count(cnt0), .o_overflow(ovf0)
    );

    uart_loader #(.ADDR_W(8), .BIG_ENDIAN(1'b0)) u_le (
        .i_clk_uart(clk), .i_rst_n(rst_n), .i_start(start),
        .i_rx_data(rx_data), .i_rx_valid(rx_valid), .i_rx_clear(rx_clear),
        .o_mem_addr(a1), .o_mem_wdata(wd1), .o_mem_we(we1),
        .i_mem_ready(mem_ready), .o_busy(busy1), .o_done(done1),
        .o_cpu_rst_n(cpu1), .o_word_count(cnt1), .o_overflow(ovf1)
    );

    uart_loader #(.ADDR_W(2), .BIG_ENDIAN(1'b1)) u_small (
        .i_clk_uart(clk), .i_rst_n(rst_n), .i_start(start),
        .i_rx_data(rx_data), .i_rx_valid(rx_valid), .i_rx_clear(rx_clear),
        .o_mem_addr(a2), .o_mem_wdata(wd2), .o_mem_we(we2),
        .i_mem_ready(mem_ready), .o_busy(busy2), .o_done(done2),
        .o_cpu_rst_n(cpu2), .o_word_count(cnt2), .o_overflow(ovf2)
    );

    // Capture accepted writes and done pulses.
    always @(posedge clk) begin
        if (!rst_n) begin
            q0.delete();
            q1.delete();
            q2.delete();
            dn0 = 0;
        end else begin
            if (we0 && mem_ready) q0.push_back({a0, wd0});
            if (we1 && mem_ready) q1.push_back({a1, wd1});
            if (we2 && mem_ready) q2.push_back({6'd0, a2, wd2});
            if (done0) dn0++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        start = 1'b0;
        rx_valid = 1'b0;
        rx_clear = 1'b0;
        rx_data = 8'h00;
        mem_ready = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic arm();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        rx_data = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        tick();
    endtask

    task automatic clear_pulse();
        rx_clear = 1'b1;
        tick();
        rx_clear = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy0 || busy1 || busy2) && n < 60) begin
            tick();
            n++;
        end
        tests++;
        if (busy0 || busy1 || busy2) begin
            fails++;
            $display("FAIL wait_idle: busy=%b%b%b want 000",
                     busy0, busy1, busy2);
        end
        tick();
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        rx_valid = 1'b0;
        rx_clear = 1'b0;
        rx_data = 8'hFF;
        mem_ready = 1'b1;
        tick();
        tests++;
        if ({a0, wd0, we0, busy0, done0, cpu0, cnt0, ovf0} !==
            {8'h00, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 9'h0, 1'b0}) begin
            fails++;
            $display("FAIL reset_be: got %h/%h we%b b%b d%b c%b n%h o%b",
                     a0, wd0, we0, busy0, done0, cpu0, cnt0, ovf0);
        end
        tests++;
        if ({a2, we2, busy2, cpu2, cnt2, ovf2} !==
            {2'd0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0}) begin
            fails++;
            $display("FAIL reset_small: got a%h we%b b%b c%b n%h o%b",
                     a2, we2, busy2, cpu2, cnt2, ovf2);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        do_reset();
        arm();
        tests++;
        if ({busy0, cpu0} !== 2'b10) begin
            fails++;
            $display("FAIL armed: busy/cpu_rst_n %b want 10", {busy0, cpu0});
        end
        for (int i = 1; i <= 8; i++) send(8'(i));
        clear_pulse();
        wait_idle();
        tests++;
        if (q0.size() !== 2) begin
            fails++;
            $display("FAIL basic_nwr: got %0d want 2", q0.size());
        end
        tests++;
        if (q0[0] !== {8'h00, 32'h01020304}) begin
            fails++;
            $display("FAIL basic_w0: got %h want 0001020304", q0[0]);
        end
        tests++;
        if (q0[1] !== {8'h01, 32'h05060708}) begin
            fails++;
            $display("FAIL basic_w1: got %h want 0105060708", q0[1]);
        end
        tests++;
        if ({dn0, cnt0, ovf0} !== {32'd1, 9'd2, 1'b0}) begin
            fails++;
            $display("FAIL basic_status: done %0d cnt %0d ovf %b want 1 2 0",
                     dn0, cnt0, ovf0);
        end
        tests++;
        if ({busy0, cpu0, done0} !== 3'b010) begin
            fails++;
            $display("FAIL basic_idle: b/c/d %b want 010",
                     {busy0, cpu0, done0});
        end
    endtask

    task automatic test_little_endian();
        do_reset();
        arm();
        send(8'h11);
        send(8'h22);
        send(8'h33);
        send(8'h44);
        clear_pulse();
        wait_idle();
        tests++;
        if (q1[0] !== {8'h00, 32'h44332211} || cnt1 !== 9'd1) begin
            fails++;
            $display("FAIL le_word: got %h cnt %0d want 0044332211 1",
                     q1[0], cnt1);
        end
        tests++;
        if (q0[0] !== {8'h00, 32'h11223344}) begin
            fails++;
            $display("FAIL be_word: got %h want 0011223344", q0[0]);
        end
    endtask

    task automatic test_partial();
        do_reset();
        arm();
        send(8'hAA);
        send(8'hBB);
        send(8'hCC);
        send(8'hDD);
        send(8'hEE);
        clear_pulse();
        wait_idle();
        tests++;
        if (q0[0] !== {8'h00, 32'hAABBCCDD}) begin
            fails++;
            $display("FAIL part_w0: got %h want 00aabbccdd", q0[0]);
        end
        tests++;
        if (q0[1] !== {8'h01, 32'hEE000000} || cnt0 !== 9'd2) begin
            fails++;
            $display("FAIL part_w1: got %h cnt %0d want 01ee000000 2",
                     q0[1], cnt0);
        end
        tests++;
        if (q1[1] !== {8'h01, 32'h000000EE}) begin
            fails++;
            $display("FAIL part_le: got %h want 01000000ee", q1[1]);
        end
    endtask

    task automatic test_stall();
        do_reset();
        mem_ready = 1'b0;
        arm();
        send(8'h10);
        send(8'h20);
        send(8'h30);
        send(8'h40);
        send(8'h50);
        for (int i = 0; i < 4; i++) tick();
        tests++;
        if ({we0, a0, wd0} !== {1'b1, 8'h00, 32'h10203040} ||
            q0.size() !== 0) begin
            fails++;
            $display("FAIL stall_hold: we %b a %h d %h n %0d want 1 00 10203040 0",
                     we0, a0, wd0, q0.size());
        end
        mem_ready = 1'b1;
        tick();
        send(8'h60);
        send(8'h70);
        send(8'h80);
        clear_pulse();
        wait_idle();
        tests++;
        if (q0[1] !== {8'h01, 32'h50607080} || ovf0 !== 1'b0) begin
            fails++;
            $display("FAIL stall_skid: got %h ovf %b want 0150607080 0",
                     q0[1], ovf0);
        end

        do_reset();
        mem_ready = 1'b0;
        arm();
        send(8'h10);
        send(8'h20);
        send(8'h30);
        send(8'h40);
        send(8'h90);
        send(8'hA0);
        tick();
        tests++;
        if (ovf0 !== 1'b1) begin
            fails++;
            $display("FAIL stall_drop: ovf %b want 1", ovf0);
        end
        mem_ready = 1'b1;
        tick();
        clear_pulse();
        wait_idle();
        tests++;
        if (q0[1] !== {8'h01, 32'h90000000} || cnt0 !== 9'd2 ||
            ovf0 !== 1'b1) begin
            fails++;
            $display("FAIL stall_drop_end: got %h cnt %0d ovf %b want 0190000000 2 1",
                     q0[1], cnt0, ovf0);
        end

        do_reset();
        mem_ready = 1'b0;
        arm();
        send(8'hC1);
        send(8'hC2);
        send(8'hC3);
        send(8'hC4);
        clear_pulse();
        tick();
        mem_ready = 1'b1;
        wait_idle();
        tests++;
        if (q0.size() !== 1 || cnt0 !== 9'd1 || dn0 !== 1) begin
            fails++;
            $display("FAIL clr_in_write: nwr %0d cnt %0d done %0d want 1 1 1",
                     q0.size(), cnt0, dn0);
        end
    endtask

    task automatic test_exhaust();
        do_reset();
        arm();
        for (int i = 1; i <= 20; i++) send(8'(i));
        clear_pulse();
        wait_idle();
        tests++;
        if (q2.size() !== 4 || q2[3] !== {8'h03, 32'h0D0E0F10}) begin
            fails++;
            $display("FAIL exh_writes: nwr %0d last %h want 4 030d0e0f10",
                     q2.size(), q2[3]);
        end
        tests++;
        if ({a2, ovf2, cnt2} !== {2'd3, 1'b1, 3'd4}) begin
            fails++;
            $display("FAIL exh_status: addr %0d ovf %b cnt %0d want 3 1 4",
                     a2, ovf2, cnt2);
        end
        tests++;
        if (q0.size() !== 5 || ovf0 !== 1'b0 || cnt0 !== 9'd5) begin
            fails++;
            $display("FAIL exh_wide: nwr %0d ovf %b cnt %0d want 5 0 5",
                     q0.size(), ovf0, cnt0);
        end
    endtask

    task automatic test_same_cycle();
        do_reset();
        arm();
        send(8'h01);
        start = 1'b1;
        tick();
        start = 1'b0;
        send(8'h02);
        send(8'h03);
        rx_data = 8'h04;
        rx_valid = 1'b1;
        rx_clear = 1'b1;
        tick();
        rx_valid = 1'b0;
        rx_clear = 1'b0;
        wait_idle();
        tests++;
        if (q0.size() !== 1 || q0[0] !== {8'h00, 32'h01020304} ||
            cnt0 !== 9'd1 || dn0 !== 1) begin
            fails++;
            $display("FAIL same_full: nwr %0d w %h cnt %0d done %0d want 1 0001020304 1 1",
                     q0.size(), q0[0], cnt0, dn0);
        end

        do_reset();
        arm();
        rx_data = 8'h5A;
        rx_valid = 1'b1;
        rx_clear = 1'b1;
        tick();
        rx_valid = 1'b0;
        rx_clear = 1'b0;
        wait_idle();
        tests++;
        if (q0[0] !== {8'h00, 32'h5A000000} || cnt0 !== 9'd1) begin
            fails++;
            $display("FAIL same_part: got %h cnt %0d want 005a000000 1",
                     q0[0], cnt0);
        end
    endtask

    task automatic test_clear_empty_reset();
        do_reset();
        arm();
        clear_pulse();
        for (int i = 0; i < 3; i++) tick();
        tests++;
        if ({busy0, cpu0, we0} !== 3'b100 || dn0 !== 0) begin
            fails++;
            $display("FAIL clr_empty: b/c/we %b done %0d want 100 0",
                     {busy0, cpu0, we0}, dn0);
        end
        mem_ready = 1'b0;
        send(8'hF1);
        send(8'hF2);
        send(8'hF3);
        send(8'hF4);
        tests++;
        if (we0 !== 1'b1) begin
            fails++;
            $display("FAIL mid_write: we %b want 1", we0);
        end
        rst_n = 1'b0;
        tick();
        tests++;
        if ({a0, wd0, we0, busy0, done0, cpu0, cnt0, ovf0} !==
            {8'h00, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 9'h0, 1'b0}) begin
            fails++;
            $display("FAIL rst_mid_write: got %h/%h we%b b%b d%b c%b n%h o%b",
                     a0, wd0, we0, busy0, done0, cpu0, cnt0, ovf0);
        end
        rst_n = 1'b1;
        mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        tests++;
        if (q0.size() !== 0 || we0 !== 1'b0 || busy0 !== 1'b0) begin
            fails++;
            $display("FAIL rst_abort: nwr %0d we %b busy %b want 0 0 0",
                     q0.size(), we0, busy0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_little_endian();
        test_partial();
        test_stall();
        test_exhaust();
        test_same_cycle();
        test_clear_empty_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_loader.md
UART_LOADER -- requirements
Module: uart_loader

Interface
REQ-001 Parameter ADDR_W, default 8: word-address width of target instruction memory.
REQ-002 Parameter BIG_ENDIAN, default 1: 1 = first received byte lands in bits [31:24]; 0 = first byte in bits [7:0].
REQ-003 i_clk_uart  in  1  single clock for all logic.
REQ-004 i_rst_n  in  1  reset, synchronous, active-low.
REQ-005 i_start  in  1  one-cycle arm request from host logic.
REQ-006 i_rx_data  in  8  byte from UART receiver.
REQ-007 i_rx_valid  in  1  one-cycle strobe; i_rx_data valid this cycle.
REQ-008 i_rx_clear  in  1  end-of-transmission indication from receiver (line idle timeout).
REQ-009 o_mem_addr  out  ADDR_W  word address of current write.
REQ-010 o_mem_wdata  out  32  assembled word.
REQ-011 o_mem_we  out  1  write request.
REQ-012 i_mem_ready  in  1  memory accepts write in any cycle where o_mem_we && i_mem_ready.
REQ-013 o_busy  out  1  high from arm until DONE.
REQ-014 o_done  out  1  one-cycle pulse on load completion.
REQ-015 o_cpu_rst_n  out  1  low (CPU held in reset) while o_busy.
REQ-016 o_word_count  out  ADDR_W+1  words written in current load.
REQ-017 o_overflow  out  1  sticky error: byte lost or address space exhausted.

Function
REQ-018 FSM states: IDLE, COLLECT, WRITE, DONE; encodings from shared package.
REQ-019 IDLE: i_start -> COLLECT next cycle; clear addr, byte index, word count, overflow, skid buffer; i_rx_* ignored in IDLE.
REQ-020 COLLECT: each i_rx_valid stores byte at byte index per BIG_ENDIAN, index += 1 (2-bit, wraps 3->0).
REQ-021 4th byte accepted at cycle N -> WRITE with o_mem_we=1 at N+1; addr/wdata stable while o_mem_we=1 and i_mem_ready=0.
REQ-022 WRITE: on accept, addr += 1, o_word_count += 1, o_mem_we drops next cycle, return to COLLECT (or DONE if flush pending).
REQ-023 One-byte skid buffer: byte arriving in WRITE is held, consumed as byte 0 of next word on COLLECT entry; second byte while buffer full -> byte dropped, o_overflow=1.
REQ-024 i_rx_clear in COLLECT with index=0 and word count=0: ignored, stay armed.
REQ-025 i_rx_clear in COLLECT with index=0 and count>0 -> DONE next cycle.
REQ-026 i_rx_clear with partial word (index 1..3): unfilled bytes zero, WRITE flush word, then DONE.
REQ-027 i_rx_valid and i_rx_clear same cycle: byte stored first, clear evaluated on updated index.
REQ-028 i_rx_clear during WRITE: latched as flush pending, acted on after write completes.
REQ-029 After write to addr 2^ADDR_W-1: further bytes dropped, o_overflow=1, addr not wrapped; FSM continues to wait for clear.
REQ-030 DONE: o_done=1 for exactly one cycle, then IDLE; o_word_count, o_overflow hold until next i_start.
REQ-031 i_start outside IDLE ignored.

Reset
REQ-032 On i_rst_n=0 at clock edge: state IDLE, o_mem_addr=0, o_mem_wdata=0, o_mem_we=0, o_busy=0, o_done=0, o_cpu_rst_n=1, o_word_count=0, o_overflow=0, skid empty.
REQ-033 Reset mid-write aborts without completing handshake; partial word discarded.

Structure
REQ-034 Shared package holds FSM state encodings and WORD_BYTES=4 constant.
REQ-035 Single module, no sub-modules; skid buffer and word assembler inline.

Verification
REQ-036 Arm, send 8 bytes 01..08, i_mem_ready=1, then clear -> writes 0x01020304@0, 0x05060708@1, done pulse, count=2.
REQ-037 BIG_ENDIAN=0, send 11 22 33 44 -> 0x44332211@0.
REQ-038 Send 5 bytes AA..EE then clear -> 0xAABBCCDD@0, 0xEE000000@1, count=2.
REQ-039 Hold i_mem_ready=0 10 cycles, send one byte mid-stall -> no loss, o_overflow=0; two bytes mid-stall -> o_overflow=1.
REQ-040 ADDR_W=2, send 20 bytes -> 4 writes addr 0..3, o_overflow=1, no addr wrap.
REQ-041 Clear with no bytes -> stays COLLECT, o_busy=1, o_cpu_rst_n=0; reset mid-WRITE -> all outputs at reset values next cycle.
